// File: rtl/collision_score_unit_pkg.sv
// Shared types and constants for the collision/score block: object kinds,
// the per-object bounding rectangle and the default point values.
package collision_pkg;

    // Storage width for rectangle bounds. It must hold COORD_W+1 bits so the
    // unwrapped world x can be compared against the bounds.
    localparam int COORD_MAX_W = 16;

    localparam int DEF_COIN_PTS  = 5;
    localparam int DEF_STOMP_PTS = 10;

    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_COIN   = 2'd1,
        KIND_STOMP  = 2'd2,
        KIND_HAZARD = 2'd3
    } obj_kind_t;

    typedef struct packed {
        logic [COORD_MAX_W-1:0] xlo;
        logic [COORD_MAX_W-1:0] xhi;
        logic [COORD_MAX_W-1:0] ylo;
        logic [COORD_MAX_W-1:0] yhi;
        obj_kind_t              kind;
    } obj_rect_t;

    // Coins and stomps are consumed and scored; hazards and empty slots are not.
    function automatic logic is_collectable(obj_kind_t k);
        return (k == KIND_COIN) || (k == KIND_STOMP);
    endfunction

endpackage

// File: rtl/collision_score_unit_if.sv
// Bundle of the per-frame player inputs, object-table write bus and the
// score/award outputs of the collision unit.
interface collision_score_unit_if #(
    parameter int NUM_OBJ = 8,
    parameter int COORD_W = 10,
    parameter int SCORE_W = 16
);
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    logic               level_restart;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;
    logic [COORD_W-1:0] scroll_x;

    logic               obj_wr_en;
    logic [IDX_W-1:0]   obj_wr_idx;
    logic [COORD_W-1:0] obj_wr_xlo;
    logic [COORD_W-1:0] obj_wr_xhi;
    logic [COORD_W-1:0] obj_wr_ylo;
    logic [COORD_W-1:0] obj_wr_yhi;
    logic [1:0]         obj_wr_kind;

    logic [NUM_OBJ-1:0] obj_hit;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic               game_over;
    logic               award_valid;
    logic [IDX_W-1:0]   award_idx;
    logic [7:0]         award_pts;

    modport master (
        output level_restart, player_x, player_y, scroll_x,
               obj_wr_en, obj_wr_idx, obj_wr_xlo, obj_wr_xhi,
               obj_wr_ylo, obj_wr_yhi, obj_wr_kind,
        input  obj_hit, score, lives, game_over,
               award_valid, award_idx, award_pts
    );

    modport slave (
        input  level_restart, player_x, player_y, scroll_x,
               obj_wr_en, obj_wr_idx, obj_wr_xlo, obj_wr_xhi,
               obj_wr_ylo, obj_wr_yhi, obj_wr_kind,
        output obj_hit, score, lives, game_over,
               award_valid, award_idx, award_pts
    );

endinterface

// File: rtl/collision_rect_cmp.sv
// Combinational strict-bounds overlap test of one point against one rectangle.
module collision_rect_cmp
    import collision_pkg::*;
(
    input  logic [COORD_MAX_W-1:0] xlo,
    input  logic [COORD_MAX_W-1:0] xhi,
    input  logic [COORD_MAX_W-1:0] ylo,
    input  logic [COORD_MAX_W-1:0] yhi,
    input  logic [COORD_MAX_W-1:0] px,
    input  logic [COORD_MAX_W-1:0] py,
    output logic                   overlap
);

    // Bounds are exclusive on every edge: touching a border is not a hit.
    assign overlap = (xlo < px) && (px < xhi) && (ylo < py) && (py < yhi);

endmodule

// File: rtl/collision_score_unit.sv
// Per-frame collision of the player against an object table: latches coin and
// stomp hits, drains one award per frame into a saturating score, and tracks
// lives with an invulnerability window after each hazard hit.
module collision_score_unit
    import collision_pkg::*;
#(
    parameter int NUM_OBJ       = 8,
    parameter int COORD_W       = 10,
    parameter int SCORE_W       = 16,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int COIN_PTS      = DEF_COIN_PTS,
    parameter int STOMP_PTS     = DEF_STOMP_PTS
) (
    input logic                   frame_clk,
    input logic                   reset,
    collision_score_unit_if.slave bus
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);

    obj_rect_t          table_q [NUM_OBJ];
    obj_rect_t          table_d [NUM_OBJ];
    logic [NUM_OBJ-1:0] hit_q, hit_d;
    logic [NUM_OBJ-1:0] pend_q, pend_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         lives_q, lives_d;
    logic               over_q, over_d;
    logic               aval_q, aval_d;
    logic [IDX_W-1:0]   aidx_q, aidx_d;
    logic [7:0]         apts_q, apts_d;
    logic [INV_W-1:0]   inv_q, inv_d;

    logic [COORD_W:0]       world_x_raw;
    logic [COORD_MAX_W-1:0] world_x, world_y;
    logic [NUM_OBJ-1:0]     overlap, collectable, hazard, first, new_hits;
    logic                   hazard_hit, sel_valid;
    logic [IDX_W-1:0]       sel_idx;
    logic [7:0]             sel_pts;
    logic [SCORE_W:0]       score_sum;
    logic [SCORE_W-1:0]     score_sat;

    // One extra bit keeps player_x + scroll_x from wrapping.
    assign world_x_raw = {1'b0, bus.player_x} + {1'b0, bus.scroll_x};
    assign world_x     = COORD_MAX_W'(world_x_raw);
    assign world_y     = COORD_MAX_W'(bus.player_y);

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        localparam logic [NUM_OBJ-1:0] LOWER = NUM_OBJ'((64'd1 << i) - 64'd1);

        collision_rect_cmp u_cmp (
            .xlo     (table_q[i].xlo),
            .xhi     (table_q[i].xhi),
            .ylo     (table_q[i].ylo),
            .yhi     (table_q[i].yhi),
            .px      (world_x),
            .py      (world_y),
            .overlap (overlap[i])
        );

        assign collectable[i] = overlap[i] && is_collectable(table_q[i].kind);
        assign hazard[i]      = overlap[i] && (table_q[i].kind == KIND_HAZARD);
        // Priority encoder stage: pending here and nothing pending below.
        assign first[i]       = pend_q[i] && !(|(pend_q & LOWER));
    end

    assign sel_valid = |pend_q;

    // Turn the one-hot lowest-pending flag into an index.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (first[i]) sel_idx = IDX_W'(i);
        end
    end

    assign sel_pts   = (table_q[sel_idx].kind == KIND_STOMP) ? 8'(STOMP_PTS) : 8'(COIN_PTS);
    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(sel_pts);
    assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    // After game over nothing new latches and lives are frozen.
    assign new_hits   = collectable & ~hit_q & {NUM_OBJ{!over_q}};
    assign hazard_hit = (|hazard) && (inv_q == '0) && (lives_q != '0) && !over_q;

    // Next-state: restart clears, else service one award, latch hits, then apply writes.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latches are inferred.
        table_d = table_q;
        hit_d   = hit_q;
        pend_d  = pend_q;
        score_d = score_q;
        lives_d = lives_q;
        over_d  = over_q;
        aval_d  = 1'b0;
        aidx_d  = '0;
        apts_d  = '0;
        inv_d   = (inv_q != '0) ? inv_q - 1'b1 : inv_q;

        if (bus.level_restart) begin
            hit_d  = '0;
            pend_d = '0;
            inv_d  = '0;
        end else begin
            if (sel_valid) begin
                pend_d[sel_idx] = 1'b0;
                aval_d          = 1'b1;
                aidx_d          = sel_idx;
                apts_d          = sel_pts;
                score_d         = score_sat;
            end
            hit_d  = hit_d | new_hits;
            pend_d = pend_d | new_hits;
            if (hazard_hit) begin
                lives_d = lives_q - 4'd1;
                inv_d   = INV_W'(INVULN_FRAMES);
                if (lives_q == 4'd1) over_d = 1'b1;
            end
            // A write on the same index as a fresh hit wins.
            if (bus.obj_wr_en) begin
                table_d[bus.obj_wr_idx] = '{xlo:  COORD_MAX_W'(bus.obj_wr_xlo),
                                            xhi:  COORD_MAX_W'(bus.obj_wr_xhi),
                                            ylo:  COORD_MAX_W'(bus.obj_wr_ylo),
                                            yhi:  COORD_MAX_W'(bus.obj_wr_yhi),
                                            kind: obj_kind_t'(bus.obj_wr_kind)};
                hit_d[bus.obj_wr_idx]  = 1'b0;
                pend_d[bus.obj_wr_idx] = 1'b0;
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge frame_clk or posedge reset) begin
        if (reset) begin
            // NOTE: the table is reset too, since empty slots must read as disabled with zero bounds.
            for (int i = 0; i < NUM_OBJ; i++) table_q[i] <= '0;
            hit_q   <= '0;
            pend_q  <= '0;
            score_q <= '0;
            lives_q <= 4'(START_LIVES);
            over_q  <= 1'b0;
            aval_q  <= 1'b0;
            aidx_q  <= '0;
            apts_q  <= '0;
            inv_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            table_q <= table_d;
            hit_q   <= hit_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            lives_q <= lives_d;
            over_q  <= over_d;
            aval_q  <= aval_d;
            aidx_q  <= aidx_d;
            apts_q  <= apts_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.obj_hit     = hit_q;
    assign bus.score       = score_q;
    assign bus.lives       = lives_q;
    assign bus.game_over   = over_q;
    assign bus.award_valid = aval_q;
    assign bus.award_idx   = aidx_q;
    assign bus.award_pts   = apts_q;

endmodule
